// File: rtl/custom_wr_arb_ctrl.sv
// -----------------------------------------------------------------------------
// custom_wr_arb_ctrl
// Write side of an async FIFO fronted by a 2-requester round-robin arbiter.
// The granted requester's data is steered to the FIFO memory write port.
// The block also keeps the binary/Gray write pointer and the registered
// full, almost-full and fill-level flags, all in the write clock domain.
//
// Ports
//   wclk_i          write-domain clock, rising edge
//   wrst_n_i        asynchronous active-low reset
//   valid_i[1:0]    per-requester write request
//   data0_i/data1_i write data of requester 0 / 1
//   rptr_sync_i     Gray read pointer, already synchronized into wclk_i
//   ready_o[1:0]    per-requester accept (write = valid & ready)
//   wen_o           FIFO memory write enable
//   waddr_o         FIFO memory write address
//   wdata_o         FIFO memory write data
//   wptr_g_o        registered Gray write pointer (to read domain)
//   wfull_o         registered full flag
//   walmost_full_o  registered almost-full flag
//   wlevel_o        registered fill level, write-domain view
//   gnt_id_o        granted requester id (meaningful while wen_o is high)
// -----------------------------------------------------------------------------
module custom_wr_arb_ctrl #(
    parameter int ADDRSIZE = 4,
    parameter int DSIZE    = 8,
    parameter int AF_LEVEL = 2
) (
    input  logic                wclk_i,
    input  logic                wrst_n_i,
    input  logic [1:0]          valid_i,
    input  logic [DSIZE-1:0]    data0_i,
    input  logic [DSIZE-1:0]    data1_i,
    input  logic [ADDRSIZE:0]   rptr_sync_i,
    output logic [1:0]          ready_o,
    output logic                wen_o,
    output logic [ADDRSIZE-1:0] waddr_o,
    output logic [DSIZE-1:0]    wdata_o,
    output logic [ADDRSIZE:0]   wptr_g_o,
    output logic                wfull_o,
    output logic                walmost_full_o,
    output logic [ADDRSIZE:0]   wlevel_o,
    output logic                gnt_id_o
);

    localparam int PW = ADDRSIZE + 1;
    // Depth and threshold built in PW bits so ADDRSIZE up to 31 does not
    // overflow 32-bit integer arithmetic.
    localparam logic [PW-1:0] DEPTH  = PW'(1) << ADDRSIZE;
    localparam logic [PW-1:0] AF_THR = DEPTH - PW'(AF_LEVEL);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_g_q, wgray_d;
    logic          prio_q, prio_d;
    logic          wfull_q, wfull_d;
    logic          walmost_full_q, walmost_full_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic [PW-1:0] rbin_sync;
    logic          gnt_id;
    logic          wen;

    // Gray -> binary: bit i is the XOR of all Gray bits at or above i.
    for (genvar i = 0; i < PW; i++) begin : g_g2b
        assign rbin_sync[i] = ^(rptr_sync_i >> i);
    end

    // Tie goes to prio; otherwise the single requester (or 0 when idle).
    assign gnt_id = (valid_i == 2'b11) ? prio_q : valid_i[1];

    // Reset gating keeps the write port quiet while wrst_n_i is low even
    // though the registered full flag reads 0 then.
    assign wen = (|valid_i) & ~wfull_q & wrst_n_i;

    assign wbin_d         = wbin_q + PW'(wen);
    assign wgray_d        = (wbin_d >> 1) ^ wbin_d;
    assign wlevel_d       = wbin_d - rbin_sync;
    // Full when the next write pointer has lapped the read pointer once:
    // Gray form of that is the top two bits inverted.
    assign wfull_d        = (wgray_d == {~rptr_sync_i[PW-1:PW-2], rptr_sync_i[PW-3:0]});
    assign walmost_full_d = (wlevel_d >= AF_THR);
    assign prio_d         = wen ? ~gnt_id : prio_q;

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            wbin_q         <= '0;
            wptr_g_q       <= '0;
            prio_q         <= 1'b0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_g_q       <= wgray_d;
            prio_q         <= prio_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
        end
    end

    assign ready_o        = wen ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign wen_o          = wen;
    assign waddr_o        = wbin_q[ADDRSIZE-1:0];
    assign wdata_o        = wrst_n_i ? (gnt_id ? data1_i : data0_i) : '0;
    assign gnt_id_o       = gnt_id & wrst_n_i;
    assign wptr_g_o       = wptr_g_q;
    assign wfull_o        = wfull_q;
    assign walmost_full_o = walmost_full_q;
    assign wlevel_o       = wlevel_q;

endmodule

// File: doc/custom_wr_arb_ctrl.md
CUSTOM_WR_ARB_CTRL -- requirements
Module: custom_wr_arb_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, FIFO address width (depth 2**ADDRSIZE, legal range 2..31).
REQ-002 SHALL have parameter DSIZE, default 8, write data width.
REQ-003 SHALL have parameter AF_LEVEL, default 2, almost-full margin in entries (1..2**ADDRSIZE-1).
REQ-004 SHALL have a single clock and reset: asynchronous, active-low reset; all logic is in the one clock domain.
REQ-005 wclk_i  in  1  write-domain clock, rising edge.
REQ-006 wrst_n_i  in  1  asynchronous active-low reset.
REQ-007 valid_i  in  2  per-requester write request; bit i belongs to requester i.
REQ-008 data0_i / data1_i  in  DSIZE each  write data of requester 0 / 1.
REQ-009 rptr_sync_i  in  ADDRSIZE+1  Gray read pointer already synchronized into wclk_i.
REQ-010 ready_o  out  2  per-requester accept; a write occurs when valid_i[i] and ready_o[i] are both high.
REQ-011 wen_o  out  1  FIFO memory write enable.
REQ-012 waddr_o  out  ADDRSIZE  FIFO memory write address.
REQ-013 wdata_o  out  DSIZE  FIFO memory write data.
REQ-014 wptr_g_o  out  ADDRSIZE+1  registered Gray write pointer, sent to read domain.
REQ-015 wfull_o  out  1  registered full flag.
REQ-016 walmost_full_o  out  1  registered almost-full flag.
REQ-017 wlevel_o  out  ADDRSIZE+1  registered fill level, write-domain view.
REQ-018 gnt_id_o  out  1  id of requester currently granted (valid when wen_o high).

Function
REQ-019 Arbiter: round robin over 2 requesters using a 1-bit priority register prio; both valid -> grant prio; one valid -> grant it; none -> no grant.
REQ-020 ready_o[g] = granted(g) & ~wfull_o; ready of non-granted requester = 0; combinational, zero latency.
REQ-021 wen_o = any grant & ~wfull_o; wdata_o = data of granted requester; gnt_id_o = granted id; waddr_o = wbin[ADDRSIZE-1:0].
REQ-022 On accepted write by requester g, prio <= ~g at next edge; prio unchanged on cycles with no write (incl. blocked by full).
REQ-023 Requester protocol: once valid_i[i] rises it holds valid and data stable until accepted; block does not check this.
REQ-024 Binary pointer wbin (ADDRSIZE+1 bits) increments by 1 per write, wraps modulo 2**(ADDRSIZE+1); wptr_g_o <= (wbin_next>>1)^wbin_next, registered with wbin.
REQ-025 wfull_o <= (wgray_next == {~rptr_sync_i[MSB:MSB-1], rptr_sync_i[MSB-2:0]}), where wgray_next is Gray of the post-write pointer.
REQ-026 rbin_sync = Gray-to-binary of rptr_sync_i; wlevel_o <= (wbin_next - rbin_sync) mod 2**(ADDRSIZE+1), range 0..2**ADDRSIZE.
REQ-027 walmost_full_o <= (wbin_next - rbin_sync) >= 2**ADDRSIZE - AF_LEVEL; asserted whenever wfull_o is.
REQ-028 Full: no write accepted; wbin, prio unchanged; flags clear at first edge after rptr_sync_i advances.
REQ-029 Write on last free entry: wfull_o rises at same edge as the write commits; next cycle ready_o = 0.
REQ-030 Flags are pessimistic: rptr_sync_i lag can only delay deassertion, never cause overflow.

Reset
REQ-031 wrst_n_i low SHALL immediately clear wbin, wptr_g_o, prio (=0), wfull_o, walmost_full_o, wlevel_o; ready_o and wen_o go low combinationally while reset asserted.
REQ-032 Reset mid-write SHALL discard the in-flight write; first write after release uses waddr_o = 0, requester 0 wins a tie.

Verification
REQ-033 ADDRSIZE=2, rptr_sync_i=0, valid_i=01 for 4 cycles -> waddr_o 0,1,2,3; wptr_g_o 001,011,010,110; wfull_o=1 after 4th write, ready_o=00.
REQ-034 valid_i=11 held 4 cycles, FIFO empty -> gnt_id_o 0,1,0,1; each requester gets 2 writes.
REQ-035 Full (wbin=100), rptr_sync_i 000 -> 001 -> wfull_o clears next edge, wlevel_o 4 -> 3, one write accepted.
REQ-036 ADDRSIZE=2, AF_LEVEL=1: 3 writes -> walmost_full_o=1, wfull_o=0, wlevel_o=3.
REQ-037 Pointer wrap: 12 writes interleaved with rptr_sync_i advances -> wbin wraps 111->000, full/level correct throughout.
REQ-038 wrst_n_i pulsed low mid-cycle during a write -> all outputs 0 asynchronously; next write to address 0.
